// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder: parallel word in over valid/ready, one bit per clock out on
// a registered serial line that feeds the pattern detector's data input.
// Words may stream back-to-back (GAP==0) or be separated by GAP idle cycles.
module serial_bit_feeder #(
  parameter int unsigned WIDTH     = 8,    // 2..32
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned GAP       = 0,    // 0..15
  parameter bit          IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic [4:0]       bit_idx,
  output logic             word_done,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  localparam logic [4:0] LAST_IDX = 5'(WIDTH - 1);
  localparam bit         HAS_GAP  = (GAP != 0);
  // The gap counter counts down to zero, so it is loaded with GAP-1.
  localparam logic [3:0] GAP_LOAD = HAS_GAP ? 4'(GAP - 1) : 4'd0;

  state_t           state_q;
  logic [WIDTH-1:0] sreg_q;
  logic [3:0]       gap_q;
  logic             sout_q;
  logic             sout_valid_q;
  logic [4:0]       bit_idx_q;
  logic             word_done_q;

  logic             last_bit;
  logic             accept;
  logic [4:0]       idx_inc_d;
  logic             first_bit_d;
  logic [WIDTH-1:0] load_sreg_d;
  logic             next_bit_d;
  logic [WIDTH-1:0] shift_sreg_d;

  // Handshake and status decode, purely from current state.
  always_comb begin
    last_bit  = (state_q == S_SHIFT) && (bit_idx_q == LAST_IDX);
    din_ready = (state_q == S_IDLE) || (last_bit && !HAS_GAP);
    accept    = din_valid && din_ready;
    busy      = (state_q != S_IDLE);
    idx_inc_d = bit_idx_q + 5'd1;
  end

  // Bit ordering: the first bit leaves on accept, the shift register keeps the
  // rest aligned so the next bit to send always sits at the same end.
  always_comb begin
    if (MSB_FIRST) begin
      first_bit_d  = din[WIDTH-1];
      load_sreg_d  = {din[WIDTH-2:0], 1'b0};
      next_bit_d   = sreg_q[WIDTH-1];
      shift_sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
    end else begin
      first_bit_d  = din[0];
      load_sreg_d  = {1'b0, din[WIDTH-1:1]};
      next_bit_d   = sreg_q[0];
      shift_sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
    end
  end

  // Control FSM with registered serial outputs; reset drops any word in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      sreg_q       <= '0;
      gap_q        <= '0;
      sout_q       <= IDLE_BIT;
      sout_valid_q <= 1'b0;
      bit_idx_q    <= '0;
      word_done_q  <= 1'b0;
    end else if (accept) begin
      // Covers both the IDLE accept and the bubble-free follow-on word.
      state_q      <= S_SHIFT;
      sreg_q       <= load_sreg_d;
      gap_q        <= '0;
      sout_q       <= first_bit_d;
      sout_valid_q <= 1'b1;
      bit_idx_q    <= '0;
      word_done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_SHIFT: begin
          if (!last_bit) begin
            sout_q      <= next_bit_d;
            sreg_q      <= shift_sreg_d;
            bit_idx_q   <= idx_inc_d;
            word_done_q <= (idx_inc_d == LAST_IDX);
          end else begin
            sout_q       <= IDLE_BIT;
            sout_valid_q <= 1'b0;
            sreg_q       <= '0;
            bit_idx_q    <= '0;
            word_done_q  <= 1'b0;
            if (HAS_GAP) begin
              state_q <= S_GAP;
              gap_q   <= GAP_LOAD;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        S_GAP: begin
          if (gap_q == 4'd0) state_q <= S_IDLE;
          else               gap_q   <= gap_q - 4'd1;
        end
        S_IDLE: begin
          // Hold idle values until a word arrives.
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
  assign bit_idx    = bit_idx_q;
  assign word_done  = word_done_q;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Scoreboard bench for serial_bit_feeder: three configurations side by side
// (8b MSB-first back-to-back, 8b with GAP=2 and IDLE_BIT=1, 4b LSB-first).
// Each accepted word pushes its per-cycle expected outputs; a negedge monitor
// pops one entry per cycle (or expects idle values when the queue is empty).
module tb_serial_bit_feeder;

  typedef struct packed {
    logic       v;
    logic       s;
    logic [4:0] idx;
    logic       done;
    logic       busy;
    logic       rdy;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] din_a [3];
  logic       dv    [3];
  logic       rdy   [3];
  logic       so    [3];
  logic       sv    [3];
  logic [4:0] bi    [3];
  logic       wd    [3];
  logic       bz    [3];

  int   n_cmp = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;
  logic cur_rdy [3];
  exp_t q0 [$];
  exp_t q1 [$];
  exp_t q2 [$];

  always #5 clk = ~clk;

  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(0), .IDLE_BIT(1'b0)) u_a (
    .clk(clk), .reset(reset), .din(din_a[0]), .din_valid(dv[0]), .din_ready(rdy[0]),
    .sout(so[0]), .sout_valid(sv[0]), .bit_idx(bi[0]), .word_done(wd[0]), .busy(bz[0]));

  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(2), .IDLE_BIT(1'b1)) u_g (
    .clk(clk), .reset(reset), .din(din_a[1]), .din_valid(dv[1]), .din_ready(rdy[1]),
    .sout(so[1]), .sout_valid(sv[1]), .bit_idx(bi[1]), .word_done(wd[1]), .busy(bz[1]));

  serial_bit_feeder #(.WIDTH(4), .MSB_FIRST(1'b0), .GAP(0), .IDLE_BIT(1'b0)) u_w (
    .clk(clk), .reset(reset), .din(din_a[2][3:0]), .din_valid(dv[2]), .din_ready(rdy[2]),
    .sout(so[2]), .sout_valid(sv[2]), .bit_idx(bi[2]), .word_done(wd[2]), .busy(bz[2]));

  function automatic int w_of(input int id);   return (id == 2) ? 4 : 8; endfunction
  function automatic int gp_of(input int id);  return (id == 1) ? 2 : 0; endfunction
  function automatic bit msb_of(input int id); return (id != 2);         endfunction
  function automatic bit ib_of(input int id);  return (id == 1);         endfunction

  function automatic exp_t idle_exp(input int id);
    exp_t e;
    e = '{v: 1'b0, s: ib_of(id), idx: 5'd0, done: 1'b0, busy: 1'b0, rdy: 1'b1};
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic qpush(input int id, input exp_t e);
    case (id)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // Expected timeline of one word from the cycle after its accept edge.
  task automatic push_word(input int id, input logic [7:0] w);
    exp_t e;
    int   n;
    n = w_of(id);
    for (int k = 0; k < n; k++) begin
      e.v    = 1'b1;
      e.s    = msb_of(id) ? w[n-1-k] : w[k];
      e.idx  = 5'(k);
      e.done = (k == n - 1);
      e.busy = 1'b1;
      e.rdy  = (k == n - 1) && (gp_of(id) == 0);
      qpush(id, e);
    end
    for (int g = 0; g < gp_of(id); g++) begin
      e = '{v: 1'b0, s: ib_of(id), idx: 5'd0, done: 1'b0, busy: 1'b1, rdy: 1'b0};
      qpush(id, e);
    end
  endtask

  task automatic mon(input int id);
    exp_t  e;
    string n;
    e = idle_exp(id);
    case (id)
      0: if (q0.size() > 0) e = q0.pop_front();
      1: if (q1.size() > 0) e = q1.pop_front();
      default: if (q2.size() > 0) e = q2.pop_front();
    endcase
    n = $sformatf("u%0d", id);
    chk({n, ".sout_valid"}, 32'(sv[id]), 32'(e.v));
    chk({n, ".sout"},       32'(so[id]), 32'(e.s));
    if (e.v) chk({n, ".bit_idx"}, 32'(bi[id]), 32'(e.idx));
    chk({n, ".word_done"},  32'(wd[id]),  32'(e.done));
    chk({n, ".busy"},       32'(bz[id]),  32'(e.busy));
    chk({n, ".din_ready"},  32'(rdy[id]), 32'(e.rdy));
    cur_rdy[id] = e.rdy;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int id = 0; id < 3; id++) mon(id);
    end
  end

  // Offer a word; while the bench expects not-ready, din_valid stays high with
  // scrambled din so only the word present at the accept edge may be sent.
  task automatic send(input int id, input logic [7:0] w, input bit hold);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk); #2;
      if (cur_rdy[id]) begin
        din_a[id] = w;
        dv[id]    = 1'b1;
        @(posedge clk);
        push_word(id, w);
        #1;
        din_a[id] = 8'($urandom);
        dv[id]    = hold;
        ok        = 1'b1;
      end else begin
        din_a[id] = 8'($urandom);
        dv[id]    = 1'b1;
      end
    end
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk); #2;
      for (int id = 0; id < 3; id++) begin
        dv[id]    = 1'b0;
        din_a[id] = 8'($urandom);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int id = 0; id < 3; id++) begin
      dv[id] = 1'b0; din_a[id] = 8'h00; cur_rdy[id] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    mon_en = 1'b1;
    idle(2);

    // Single word, then back-to-back pair with din_valid held.
    send(0, 8'hD0, 1'b0);
    idle(3);
    send(0, 8'hA5, 1'b1);
    send(0, 8'h3C, 1'b0);
    idle(3);

    // Reset asserted during cycle 4 of a word: the rest of it is discarded.
    send(0, 8'hB4, 1'b0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    q0.delete(); q1.delete(); q2.delete();
    #1 reset = 1'b0;
    idle(2);
    send(0, 8'h5A, 1'b0);
    idle(10);

    // GAP=2: second word held through the gap, accepted on the IDLE cycle.
    send(1, 8'hFF, 1'b1);
    send(1, 8'h0D, 1'b0);
    idle(12);

    // 4-bit LSB-first.
    send(2, 8'h0B, 1'b0);
    idle(6);

    chk("queue_drain", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
